// File: rtl/run_ctrl.sv
// run_ctrl: byte-stream program loader and run/step/pause sequencer for the RISC-V core; breakpoint option RUNCTRL_BREAKPOINT_EN
module run_ctrl #(
  parameter int IMEM_WORDS = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [7:0]    load_data,
  input  logic          load_last,
  input  logic          run_req,
  input  logic          step_req,
  input  logic          halt_req,
  input  logic [31:0]   pc,
  input  logic [31:0]   instr,
`ifdef RUNCTRL_BREAKPOINT_EN
  input  logic          bp_valid,
  input  logic [31:0]   bp_addr,
`endif
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_reset,
  output logic          cpu_en,
  output logic [2:0]    state,
  output logic [31:0]   retired,
  output logic          load_ovf,
  output logic          bp_hit
);
  typedef enum logic [2:0] {IDLE, LOAD, PAUSE, RUN, STEP, DONE} state_t;
  localparam logic [AW-1:0] LASTW = AW'(IMEM_WORDS - 1);
  state_t r_state, w_next;
  logic [AW-1:0] r_idx;
  logic [1:0] r_k;
  logic [23:0] r_buf;
  logic [31:0] r_retired;
  logic r_ovf;
  logic w_acc, w_we, w_full, w_halt_ins, w_bp, w_enter_load;
  logic [31:0] w_word;
  assign load_ready = r_state == LOAD;
  assign w_acc = load_ready && load_valid;
  assign w_we = w_acc && (r_k == 2'd3 || load_last);
  assign w_full = w_we && r_idx == LASTW;
  assign w_word = {8'h0, r_buf} | ({24'h0, load_data} << {r_k, 3'b000});
  assign w_halt_ins = instr == 32'h0000006F;
  assign w_enter_load = w_next == LOAD && r_state != LOAD;
  assign imem_we = w_we;
  assign imem_addr = r_idx;
  assign imem_wdata = w_we ? w_word : '0;
  assign cpu_reset = r_state == IDLE || r_state == LOAD;
  assign state = r_state;
  assign retired = r_retired;
  assign load_ovf = r_ovf;
`ifdef RUNCTRL_BREAKPOINT_EN
  logic r_first, r_bp_hit;
  assign w_bp = bp_valid && pc == bp_addr && !r_first;
  assign bp_hit = r_bp_hit;
  // Flag the first RUN cycle after a pause so resuming steps off a breakpoint; register the hit pulse
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_first <= 1'b0;
      r_bp_hit <= 1'b0;
    end else begin
      r_first <= r_state == PAUSE;
      r_bp_hit <= r_state == RUN && w_bp && !w_halt_ins;
    end
`else
  logic w_unused;
  assign w_unused = ^pc;
  assign w_bp = 1'b0;
  assign bp_hit = 1'b0;
`endif
  // Next state and core clock-enable; halt instruction beats breakpoint beats halt_req
  always_comb begin
    w_next = r_state;
    cpu_en = 1'b0;
    case (r_state)
      IDLE:  w_next = load_start ? LOAD : IDLE;
      LOAD:  w_next = (w_acc && load_last) || w_full ? PAUSE : LOAD;
      PAUSE: w_next = load_start ? LOAD : step_req ? STEP : run_req ? RUN : PAUSE;
      RUN: begin
        cpu_en = !w_halt_ins && !w_bp && !halt_req;
        w_next = w_halt_ins ? DONE : (w_bp || halt_req) ? PAUSE : RUN;
      end
      STEP: begin
        cpu_en = !w_halt_ins;
        w_next = w_halt_ins ? DONE : PAUSE;
      end
      DONE:  w_next = load_start ? LOAD : DONE;
      default: w_next = IDLE;
    endcase
  end
  // State register, word assembly, overflow flag and retired-instruction counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_k <= '0;
      r_buf <= '0;
      r_retired <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_enter_load) begin
        r_idx <= '0;
        r_k <= '0;
        r_buf <= '0;
        r_retired <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_we) begin
          r_idx <= r_idx + 1'b1;
          r_k <= '0;
          r_buf <= '0;
        end else if (w_acc) begin
          r_k <= r_k + 1'b1;
          r_buf <= w_word[23:0];
        end
        if (w_full && !load_last) r_ovf <= 1'b1;
        if (cpu_en) r_retired <= r_retired + 1'b1;
      end
    end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized self-checking bench for run_ctrl with a small core/memory model
module tb_run_ctrl;
  logic clk = 0, reset = 1, load_start = 0, load_valid = 0, load_last = 0;
  logic run_req = 0, step_req = 0, halt_req = 0;
  logic [7:0] load_data = 0;
  logic [31:0] pc, instr;
  logic ready0, we0, cres0, en0, ovf0, bp0, ready1, we1, cres1, en1, ovf1, bp1;
  logic [5:0] addr0, addr1;
  logic [31:0] wdata0, wdata1, ret0, ret1;
  logic [2:0] st0, st1;
`ifdef RUNCTRL_BREAKPOINT_EN
  logic bp_valid = 0;
  logic [31:0] bp_addr = 0;
`endif
  int checks = 0, errors = 0, en_cnt = 0, bp_cnt = 0;
  logic [31:0] mem [64];
  logic [31:0] prog [64];
  logic [37:0] wq0 [$], wq1 [$];

  run_ctrl u0 (.clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_ready(ready0), .load_data(load_data), .load_last(load_last), .run_req(run_req),
    .step_req(step_req), .halt_req(halt_req), .pc(pc), .instr(instr),
`ifdef RUNCTRL_BREAKPOINT_EN
    .bp_valid(bp_valid), .bp_addr(bp_addr),
`endif
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0), .cpu_reset(cres0), .cpu_en(en0),
    .state(st0), .retired(ret0), .load_ovf(ovf0), .bp_hit(bp0));

  run_ctrl #(.IMEM_WORDS(2)) u1 (.clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_ready(ready1), .load_data(load_data), .load_last(load_last), .run_req(run_req),
    .step_req(step_req), .halt_req(halt_req), .pc(pc), .instr(instr),
`ifdef RUNCTRL_BREAKPOINT_EN
    .bp_valid(bp_valid), .bp_addr(bp_addr),
`endif
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1), .cpu_reset(cres1), .cpu_en(en1),
    .state(st1), .retired(ret1), .load_ovf(ovf1), .bp_hit(bp1));

  always #5 clk = ~clk;

  always @(posedge clk) if (we0) mem[addr0] <= wdata0;
  always @(posedge clk or posedge reset)
    if (reset) pc <= 0;
    else if (cres0) pc <= 0;
    else if (en0) pc <= pc + 4;
  assign instr = mem[pc[7:2]];

  always @(negedge clk) begin
    if (we0) wq0.push_back({addr0, wdata0});
    if (we1) wq1.push_back({addr1, wdata1});
    if (en0) en_cnt++;
    if (bp0) bp_cnt++;
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic do_reset();
    reset = 1; tick(); tick(); reset = 0; tick();
    wq0.delete(); wq1.delete();
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    load_valid = 1; load_data = d; load_last = l; tick();
    load_valid = 0; load_last = 0;
  endtask
  task automatic load_prog(input int n);
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 4; b++) send(prog[i][8*b +: 8], i == n - 1 && b == 3);
  endtask

  task automatic test_reset();
    reset = 1; @(negedge clk);
    checks++; if ({st0, cres0, en0, ready0, we0} !== 7'b0001000) begin errors++;
      $display("FAIL reset_ctrl: got %b want 0001000", {st0, cres0, en0, ready0, we0}); end
    checks++; if ({addr0, wdata0} !== 38'h0) begin errors++;
      $display("FAIL reset_imem: got %h want 0", {addr0, wdata0}); end
    checks++; if ({ret0, ovf0, bp0} !== 34'h0) begin errors++;
      $display("FAIL reset_cnt: got %h want 0", {ret0, ovf0, bp0}); end
    tick(); reset = 0; tick();
  endtask

  task automatic test_idle_ignore();
    int e = en_cnt;
    run_req = 1; step_req = 1; tick(); tick(); run_req = 0; step_req = 0; @(negedge clk);
    checks++; if (st0 !== 3'd0 || en_cnt != e) begin errors++;
      $display("FAIL idle_ignore: state %0d en %0d want 0 0", st0, en_cnt - e); end
  endtask

  task automatic test_load_fixed();
    logic [7:0] fb [8] = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    logic [7:0] rb [4];
    logic [31:0] w0;
    do_reset();
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 8; i++) send(fb[i], i == 7);
    @(negedge clk);
    checks++; if (wq0.size() != 2) begin errors++; $display("FAIL fixed_cnt: got %0d want 2", wq0.size()); end
    else begin
      checks++; if (wq0[0] !== {6'd0, 32'h00100513}) begin errors++; $display("FAIL fixed_w0: got %h want 000100513", wq0[0]); end
      checks++; if (wq0[1] !== {6'd1, 32'h0000006F}) begin errors++; $display("FAIL fixed_w1: got %h want 10000006f", wq0[1]); end
    end
    checks++; if (st0 !== 3'd2 || cres0 !== 1'b0) begin errors++;
      $display("FAIL fixed_pause: state %0d cpu_reset %b want 2 0", st0, cres0); end
    wq0.delete();
    load_start = 1; tick(); load_start = 0;
    w0 = 0;
    for (int i = 0; i < 4; i++) begin rb[i] = 8'($urandom); w0 |= 32'(rb[i]) << (8 * i); send(rb[i], 0); end
    send(8'hAA, 1); @(negedge clk);
    checks++; if (wq0.size() != 2) begin errors++; $display("FAIL five_cnt: got %0d want 2", wq0.size()); end
    else begin
      checks++; if (wq0[0] !== {6'd0, w0}) begin errors++; $display("FAIL five_w0: got %h want %h", wq0[0], {6'd0, w0}); end
      checks++; if (wq0[1] !== {6'd1, 32'h000000AA}) begin errors++; $display("FAIL five_w1: got %h want 1000000aa", wq0[1]); end
    end
  endtask

  task automatic test_load_random();
    logic [7:0] bq [$];
    logic [31:0] ew;
    int n, nw;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      bq.delete();
      n = $urandom_range(1, 24);
      nw = (n + 3) / 4;
      load_start = 1; tick(); load_start = 0;
      for (int i = 0; i < n; i++) begin
        bq.push_back(8'($urandom));
        if ($urandom_range(0, 3) == 0) tick();
        send(bq[i], i == n - 1);
      end
      @(negedge clk);
      checks++; if (wq0.size() != nw) begin errors++; $display("FAIL rnd_cnt: got %0d want %0d", wq0.size(), nw); end
      else for (int j = 0; j < nw; j++) begin
        ew = 0;
        for (int b = 0; b < 4; b++) if (j * 4 + b < n) ew |= 32'(bq[j * 4 + b]) << (8 * b);
        checks++; if (wq0[j] !== {6'(j), ew}) begin errors++;
          $display("FAIL rnd_word%0d: got %h want %h", j, wq0[j], {6'(j), ew}); end
      end
      checks++; if (st0 !== 3'd2 || ovf0 !== 1'b0) begin errors++;
        $display("FAIL rnd_end: state %0d ovf %b want 2 0", st0, ovf0); end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b [12];
    logic [31:0] e0, e1;
    do_reset();
    e0 = 0; e1 = 0;
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 12; i++) begin
      b[i] = 8'($urandom);
      if (i < 4) e0 |= 32'(b[i]) << (8 * i);
      else if (i < 8) e1 |= 32'(b[i]) << (8 * (i - 4));
      send(b[i], i == 11);
    end
    @(negedge clk);
    checks++; if (wq1.size() != 2) begin errors++; $display("FAIL ovf_cnt: got %0d want 2", wq1.size()); end
    else begin
      checks++; if (wq1[0] !== {6'd0, e0} || wq1[1] !== {6'd1, e1}) begin errors++;
        $display("FAIL ovf_words: got %h %h want %h %h", wq1[0], wq1[1], {6'd0, e0}, {6'd1, e1}); end
    end
    checks++; if ({ovf1, ready1, st1} !== 5'b10010) begin errors++;
      $display("FAIL ovf_state: got %b want 10010", {ovf1, ready1, st1}); end
    checks++; if (ovf0 !== 1'b0 || wq0.size() != 3) begin errors++;
      $display("FAIL ovf_big: ovf %b writes %0d want 0 3", ovf0, wq0.size()); end
  endtask

  task automatic test_step_run();
    int e;
    do_reset();
    prog[0] = 32'h13; prog[1] = 32'h13; prog[2] = 32'h6F; prog[3] = 32'h13;
    load_prog(4);
    e = en_cnt;
    step_req = 1; tick(); step_req = 0; @(negedge clk);
    checks++; if (en0 !== 1'b1) begin errors++; $display("FAIL step_lat: got %b want 1", en0); end
    repeat (3) tick(); @(negedge clk);
    checks++; if (en_cnt - e != 1 || ret0 !== 32'd1 || st0 !== 3'd2) begin errors++;
      $display("FAIL step: en %0d retired %0d state %0d want 1 1 2", en_cnt - e, ret0, st0); end
    run_req = 1; tick(); run_req = 0;
    for (int i = 0; i < 20 && st0 !== 3'd5; i++) tick();
    checks++; if (st0 !== 3'd5) begin errors++; $display("FAIL done_wait: state %0d want 5", st0); end
    repeat (3) tick(); @(negedge clk);
    checks++; if (ret0 !== 32'd2 || en0 !== 1'b0 || en_cnt - e != 2 || pc !== 32'd8) begin errors++;
      $display("FAIL done: retired %0d en %b cnt %0d pc %0d want 2 0 2 8", ret0, en0, en_cnt - e, pc); end
  endtask

  task automatic test_done_hold();
    int e = en_cnt;
    run_req = 1; step_req = 1; tick(); tick(); run_req = 0; step_req = 0; @(negedge clk);
    checks++; if (st0 !== 3'd5 || en_cnt != e) begin errors++;
      $display("FAIL done_hold: state %0d en %0d want 5 0", st0, en_cnt - e); end
    load_start = 1; tick(); load_start = 0; @(negedge clk);
    checks++; if (st0 !== 3'd1 || ret0 !== 32'd0 || cres0 !== 1'b1) begin errors++;
      $display("FAIL done_reload: state %0d retired %0d cpu_reset %b want 1 0 1", st0, ret0, cres0); end
  endtask

  task automatic test_run_halt();
    int n, exp;
    do_reset();
    for (int i = 0; i < 40; i++) begin prog[i] = $urandom; if (prog[i] == 32'h6F) prog[i] = 32'h13; end
    load_prog(40);
    exp = 0;
    for (int it = 0; it < 3; it++) begin
      n = it == 0 ? 10 : $urandom_range(3, 12);
      run_req = 1; tick(); run_req = 0;
      repeat (n) tick();
      halt_req = 1; @(negedge clk);
      checks++; if (en0 !== 1'b0) begin errors++; $display("FAIL halt_lat: got %b want 0", en0); end
      tick(); halt_req = 0; exp += n; @(negedge clk);
      checks++; if (ret0 !== 32'(exp) || st0 !== 3'd2 || pc !== 32'(4 * exp)) begin errors++;
        $display("FAIL halt: retired %0d state %0d pc %0d want %0d 2 %0d", ret0, st0, pc, exp, 4 * exp); end
    end
    run_req = 1; tick(); run_req = 0; tick(); tick();
    reset = 1; #1;
    checks++; if (st0 !== 3'd0 || cres0 !== 1'b1 || en0 !== 1'b0) begin errors++;
      $display("FAIL run_reset: state %0d cpu_reset %b en %b want 0 1 0", st0, cres0, en0); end
    tick(); reset = 0; tick();
  endtask

  task automatic test_breakpoint();
`ifdef RUNCTRL_BREAKPOINT_EN
    int b;
    do_reset();
    for (int i = 0; i < 16; i++) prog[i] = 32'h13;
    load_prog(16);
    bp_addr = 8; bp_valid = 1; b = bp_cnt;
    run_req = 1; tick(); run_req = 0;
    for (int i = 0; i < 20 && st0 !== 3'd2; i++) tick();
    tick(); tick(); @(negedge clk);
    checks++; if (st0 !== 3'd2 || pc !== 32'd8 || ret0 !== 32'd2 || bp_cnt - b != 1) begin errors++;
      $display("FAIL bp_stop: state %0d pc %0d retired %0d hits %0d want 2 8 2 1", st0, pc, ret0, bp_cnt - b); end
    run_req = 1; tick(); run_req = 0;
    repeat (5) tick();
    halt_req = 1; tick(); halt_req = 0; @(negedge clk);
    checks++; if (pc !== 32'd28 || ret0 !== 32'd7 || bp_cnt - b != 1) begin errors++;
      $display("FAIL bp_resume: pc %0d retired %0d hits %0d want 28 7 1", pc, ret0, bp_cnt - b); end
    bp_valid = 0;
`else
    checks++; if (bp_cnt != 0) begin errors++; $display("FAIL bp_tied: got %0d pulses want 0", bp_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_load_fixed();
    test_load_random();
    test_overflow();
    test_step_run();
    test_done_hold();
    test_run_halt();
    test_breakpoint();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
endmodule
